// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared control types, bundle struct and helpers for the ID/EX stage
package ControlTypeDefs;

  typedef enum logic [3:0] {
    R_TYPE, I_TYPE, LOAD, STORE, BRANCH, JUMP, JALR, LUI, AUIPC
  } InstructionTypes;

  localparam logic [2:0] RESULT_SRC_LOAD = 3'b001;

  typedef struct packed {
    InstructionTypes itype;
    logic [2:0]      result_src;
    logic            alu_src;
    logic            reg_write;
    logic            mem_write;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [31:0]     rd1;
    logic [31:0]     rd2;
    logic [31:0]     imm;
    logic [31:0]     pc;
  } id_ex_bundle_t;

  function automatic logic uses_rs2(input InstructionTypes t);
    return t inside {R_TYPE, STORE, BRANCH};
  endfunction

  // A bubble keeps stale fields but must never write the register file or memory.
  function automatic id_ex_bundle_t squash(input id_ex_bundle_t b);
    id_ex_bundle_t r;
    r = b;
    r.reg_write = 1'b0;
    r.mem_write = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// rtl/id_ex_stage_load_use_detect.sv - combinational load-use hazard compare against the held EX bundle
module load_use_detect
  import ControlTypeDefs::*;
(
  input  logic            ex_valid,
  input  logic [2:0]      ex_result_src,
  input  logic [4:0]      ex_rd,
  input  logic            id_valid,
  input  InstructionTypes id_type,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  output logic            hazard
);

  assign hazard = ex_valid && (ex_result_src == RESULT_SRC_LOAD) && (ex_rd != 5'd0) && id_valid
                  && ((ex_rd == id_rs1) || ((ex_rd == id_rs2) && uses_rs2(id_type)));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use stall and flush
// Optional one-entry skid buffer enabled by defining ID_EX_SKID_BUFFER_EN.
module id_ex_stage
  import ControlTypeDefs::*;
(
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iIdValid,
  output logic            oIdReady,
  input  InstructionTypes iInstructionType,
  input  logic [2:0]      iResultSrc,
  input  logic            iAluSrc,
  input  logic            iRegWrite,
  input  logic            iMemWrite,
  input  logic [4:0]      iRs1,
  input  logic [4:0]      iRs2,
  input  logic [4:0]      iRd,
  input  logic [31:0]     iRD1,
  input  logic [31:0]     iRD2,
  input  logic [31:0]     iImm,
  input  logic [31:0]     iPC,
  input  logic            iFlush,
  output logic            oExValid,
  input  logic            iExReady,
  output InstructionTypes oInstructionType,
  output logic [2:0]      oResultSrc,
  output logic            oAluSrc,
  output logic            oRegWrite,
  output logic            oMemWrite,
  output logic [4:0]      oRs1,
  output logic [4:0]      oRs2,
  output logic [4:0]      oRd,
  output logic [31:0]     oRD1,
  output logic [31:0]     oRD2,
  output logic [31:0]     oImm,
  output logic [31:0]     oPC,
  output logic            oLoadUseStall
);

  id_ex_bundle_t in_b;
  id_ex_bundle_t out_b;
  logic          out_valid;
  logic          hazard;
  logic          accept;
  logic          advance;

  assign in_b = '{itype: iInstructionType, result_src: iResultSrc, alu_src: iAluSrc,
                  reg_write: iRegWrite, mem_write: iMemWrite, rs1: iRs1, rs2: iRs2, rd: iRd,
                  rd1: iRD1, rd2: iRD2, imm: iImm, pc: iPC};

  load_use_detect u_load_use_detect (
    .ex_valid      (out_valid),
    .ex_result_src (out_b.result_src),
    .ex_rd         (out_b.rd),
    .id_valid      (iIdValid),
    .id_type       (iInstructionType),
    .id_rs1        (iRs1),
    .id_rs2        (iRs2),
    .hazard        (hazard)
  );

  assign advance = !out_valid || iExReady;
  assign accept  = iIdValid && oIdReady;

`ifdef ID_EX_SKID_BUFFER_EN
  id_ex_bundle_t skid_b;
  logic          skid_valid;

  // Ready depends only on registered state and ID-side inputs, never on iExReady.
  assign oIdReady = !skid_valid && !hazard && !iFlush;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      out_valid  <= 1'b0;
      out_b      <= '0;
      skid_valid <= 1'b0;
      skid_b     <= '0;
    end else if (iFlush) begin
      out_valid  <= 1'b0;
      out_b      <= squash(out_b);
      skid_valid <= 1'b0;
    end else if (advance) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_b      <= skid_b;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_b     <= in_b;
      end else begin
        out_valid <= 1'b0;
        out_b     <= squash(out_b);
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_b     <= in_b;
    end
  end
`else
  assign oIdReady = advance && !hazard && !iFlush;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      out_valid <= 1'b0;
      out_b     <= '0;
    end else if (iFlush) begin
      out_valid <= 1'b0;
      out_b     <= squash(out_b);
    end else if (advance) begin
      if (accept) begin
        out_valid <= 1'b1;
        out_b     <= in_b;
      end else begin
        out_valid <= 1'b0;
        out_b     <= squash(out_b);
      end
    end
  end
`endif

  assign oExValid         = out_valid;
  assign oInstructionType = out_b.itype;
  assign oResultSrc       = out_b.result_src;
  assign oAluSrc          = out_b.alu_src;
  assign oRegWrite        = out_b.reg_write;
  assign oMemWrite        = out_b.mem_write;
  assign oRs1             = out_b.rs1;
  assign oRs2             = out_b.rs2;
  assign oRd              = out_b.rd;
  assign oRD1             = out_b.rd1;
  assign oRD2             = out_b.rd2;
  assign oImm             = out_b.imm;
  assign oPC              = out_b.pc;
  assign oLoadUseStall    = hazard;

endmodule
